senzor_poll_ctrl: RTL and testbench

APB master that sequences the colour-sensor core (senzor_top) over its APB slave port. On start it writes the sensor CTRL register. It then repeatedly polls STATUS for data-ready and reads the Clear/Red/Green/Blue data registers. Each completed set is presented as one sample on a valid/ready output. It replaces bench-driven APB traffic in the integrated sensor subsystem.

---
 rtl/senzor_pkg.sv | 33 +++
 rtl/apb_master_xfer.sv | 78 +++++++
 rtl/senzor_poll_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_senzor_poll_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/senzor_pkg.sv
// Shared definitions for the colour-sensor poll controller.
// Contents: sensor register byte addresses, CTRL field positions,
// error codes, controller FSM states and APB transfer phases.
package senzor_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_DATA_C = 8'h08;
   localparam logic [7:0] ADDR_DATA_R = 8'h0C;
   localparam logic [7:0] ADDR_DATA_G = 8'h10;
   localparam logic [7:0] ADDR_DATA_B = 8'h14;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_GAIN_LSB  = 1;
   localparam int CTRL_ITIME_LSB = 8;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_SLV     = 2'd1,
      ERR_RDY_TO  = 2'd2,
      ERR_POLL_TO = 2'd3
   } err_code_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_CFG, ST_POLL, ST_GAP, ST_RD_C,
      ST_RD_R, ST_RD_G, ST_RD_B, ST_OUT, ST_DIS
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE, PH_SETUP, PH_ACCESS
   } phase_e;

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine. A req pulse while idle launches one
// SETUP + ACCESS sequence; done/slverr/timeout are single-cycle flags
// valid in the completing ACCESS cycle.
// Ports: req/addr/write/wdata (request), busy/done/rdata/slverr/timeout
// (status), psel/penable/paddr/pwrite/pwdata/pready/prdata/pslverr (APB).
module apb_master_xfer
   import senzor_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int PREADY_TO  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  slverr,
   output logic                  timeout,
   output logic                  psel,
   output logic                  penable,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);
   localparam int CW = $clog2(PREADY_TO + 1);

   phase_e          ph;
   logic [CW-1:0]   wait_cnt;

   assign psel    = (ph != PH_IDLE);
   assign penable = (ph == PH_ACCESS);
   assign busy    = psel;
   assign done    = penable && pready;
   assign slverr  = done && pslverr;
   assign timeout = penable && !pready && (wait_cnt == '0);
   assign rdata   = prdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       <= PH_IDLE;
         wait_cnt <= '0;
         paddr    <= '0;
         pwrite   <= 1'b0;
         pwdata   <= '0;
      end else begin
         case (ph)
            PH_IDLE: begin
               if (req) begin
                  ph     <= PH_SETUP;
                  paddr  <= addr;
                  pwrite <= write;
                  pwdata <= write ? wdata : '0;
               end
            end
            PH_SETUP: begin
               ph       <= PH_ACCESS;
               wait_cnt <= CW'(PREADY_TO - 1);
            end
            PH_ACCESS: begin
               if (pready || (wait_cnt == '0))
                  ph <= PH_IDLE;
               else
                  wait_cnt <= wait_cnt - CW'(1);
            end
            default: ph <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/senzor_poll_ctrl.sv
// APB master sequencing senzor_top: CTRL write on start, STATUS polling
// with a fixed idle gap, C/R/G/B reads, one valid/ready sample per set,
// CTRL=0 write on stop or poll timeout.
// Ports: start/stop/cfg_* (control), APB master port, smp_* (sample
// stream), busy/err/err_code (status).
//
// state   | meaning
// IDLE    | waiting for start
// CFG     | writing CTRL enable word
// POLL    | reading STATUS
// GAP     | idle POLL_GAP cycles between STATUS reads
// RD_C..B | reading one data channel
// OUT     | sample held on smp_* until smp_ready
// DIS     | writing CTRL=0, then IDLE
module senzor_poll_ctrl
   import senzor_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int POLL_GAP   = 16,
   parameter int MAX_POLLS  = 255,
   parameter int PREADY_TO  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            cfg_gain,
   input  logic [7:0]            cfg_itime,
   output logic                  psel,
   output logic                  penable,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr,
   output logic                  smp_valid,
   input  logic                  smp_ready,
   output logic [15:0]           smp_c,
   output logic [15:0]           smp_r,
   output logic [15:0]           smp_g,
   output logic [15:0]           smp_b,
   output logic                  busy,
   output logic                  err,
   output logic [1:0]            err_code
);
   localparam int         GW        = $clog2(POLL_GAP + 1);
   localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);

   state_e                state_q, state_d;
   logic                  stop_pend, stop_now;
   logic [1:0]            gain_q;
   logic [7:0]            itime_q;
   logic [7:0]            poll_cnt;
   logic [GW-1:0]         gap_cnt;
   err_code_e             err_code_q, err_val;
   logic                  err_set;
   logic [DATA_WIDTH-1:0] ctrl_val;

   logic                  x_req, x_write, x_busy, x_done, x_slverr, x_timeout, x_ok;
   logic [ADDR_WIDTH-1:0] x_addr;
   logic [DATA_WIDTH-1:0] x_wdata, x_rdata;
   logic                  unused_rdata_hi;

   apb_master_xfer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .PREADY_TO  (PREADY_TO)
   ) u_xfer (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (x_req),
      .addr    (x_addr),
      .write   (x_write),
      .wdata   (x_wdata),
      .busy    (x_busy),
      .done    (x_done),
      .rdata   (x_rdata),
      .slverr  (x_slverr),
      .timeout (x_timeout),
      .psel    (psel),
      .penable (penable),
      .paddr   (paddr),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   assign x_ok            = x_done && !x_slverr;
   assign stop_now        = stop_pend || stop;
   assign smp_valid       = (state_q == ST_OUT);
   assign busy            = (state_q != ST_IDLE);
   assign err_code        = err_code_q;
   assign unused_rdata_hi = ^x_rdata[DATA_WIDTH-1:16];

   always_comb begin
      ctrl_val = '0;
      ctrl_val[CTRL_EN_BIT]            = 1'b1;
      ctrl_val[CTRL_GAIN_LSB +: 2]     = gain_q;
      ctrl_val[CTRL_ITIME_LSB +: 8]    = itime_q;
   end

   // GAP shares the STATUS address so its final cycle can launch the
   // poll read, keeping exactly POLL_GAP idle bus cycles between reads.
   always_comb begin
      x_addr  = '0;
      x_write = 1'b0;
      x_wdata = '0;
      case (state_q)
         ST_CFG: begin
            x_addr  = ADDR_WIDTH'(ADDR_CTRL);
            x_write = 1'b1;
            x_wdata = ctrl_val;
         end
         ST_POLL, ST_GAP: x_addr = ADDR_WIDTH'(ADDR_STATUS);
         ST_RD_C:         x_addr = ADDR_WIDTH'(ADDR_DATA_C);
         ST_RD_R:         x_addr = ADDR_WIDTH'(ADDR_DATA_R);
         ST_RD_G:         x_addr = ADDR_WIDTH'(ADDR_DATA_G);
         ST_RD_B:         x_addr = ADDR_WIDTH'(ADDR_DATA_B);
         ST_DIS: begin
            x_addr  = ADDR_WIDTH'(ADDR_CTRL);
            x_write = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      x_req   = 1'b0;
      err_set = 1'b0;
      err_val = ERR_NONE;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_CFG;
         ST_CFG: begin
            x_req = !x_busy;
            if (x_ok) state_d = stop_now ? ST_DIS : ST_POLL;
         end
         ST_POLL: begin
            x_req = !x_busy;
            if (x_ok) begin
               if (x_rdata[0]) begin
                  state_d = ST_RD_C;
               end else if (poll_cnt == POLL_LAST) begin
                  state_d = ST_DIS;
                  err_set = 1'b1;
                  err_val = ERR_POLL_TO;
               end else begin
                  state_d = stop_now ? ST_DIS : ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GW'(1)) begin
               if (stop_now) begin
                  state_d = ST_DIS;
               end else begin
                  x_req   = 1'b1;
                  state_d = ST_POLL;
               end
            end
         end
         ST_RD_C: begin x_req = !x_busy; if (x_ok) state_d = ST_RD_R; end
         ST_RD_R: begin x_req = !x_busy; if (x_ok) state_d = ST_RD_G; end
         ST_RD_G: begin x_req = !x_busy; if (x_ok) state_d = ST_RD_B; end
         ST_RD_B: begin x_req = !x_busy; if (x_ok) state_d = ST_OUT;  end
         ST_OUT:  if (smp_ready) state_d = stop_now ? ST_DIS : ST_GAP;
         ST_DIS: begin
            x_req = !x_busy;
            if (x_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (x_slverr) begin
         state_d = ST_IDLE;
         err_set = 1'b1;
         err_val = ERR_SLV;
      end else if (x_timeout) begin
         state_d = ST_IDLE;
         err_set = 1'b1;
         err_val = ERR_RDY_TO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         stop_pend  <= 1'b0;
         gain_q     <= '0;
         itime_q    <= '0;
         poll_cnt   <= '0;
         gap_cnt    <= '0;
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
         smp_c      <= '0;
         smp_r      <= '0;
         smp_g      <= '0;
         smp_b      <= '0;
      end else begin
         state_q <= state_d;

         if (state_q == ST_IDLE) begin
            stop_pend <= start && stop;
            if (start) begin
               gain_q     <= cfg_gain;
               itime_q    <= cfg_itime;
               err        <= 1'b0;
               err_code_q <= ERR_NONE;
            end
         end else if (stop) begin
            stop_pend <= 1'b1;
         end

         if (err_set) begin
            err        <= 1'b1;
            err_code_q <= err_val;
         end

         if (state_q == ST_IDLE)
            poll_cnt <= '0;
         else if (state_q == ST_POLL && x_ok)
            poll_cnt <= x_rdata[0] ? 8'd0 :
                        (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;

         if (state_q != ST_GAP)
            gap_cnt <= GW'(POLL_GAP);
         else
            gap_cnt <= gap_cnt - GW'(1);

         if (x_ok) begin
            case (state_q)
               ST_RD_C: smp_c <= x_rdata[15:0];
               ST_RD_R: smp_r <= x_rdata[15:0];
               ST_RD_G: smp_g <= x_rdata[15:0];
               ST_RD_B: smp_b <= x_rdata[15:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_senzor_poll_ctrl.sv
module tb_senzor_poll_ctrl;
   localparam int POLL_GAP  = 16;
   localparam int MAX_POLLS = 255;
   localparam int PREADY_TO = 64;

   logic        clk = 1'b0;
   logic        rst_n, start, stop, smp_ready;
   logic [1:0]  cfg_gain;
   logic [7:0]  cfg_itime;
   logic        psel, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;
   logic        smp_valid, busy, err;
   logic [15:0] smp_c, smp_r, smp_g, smp_b;
   logic [1:0]  err_code;

   typedef struct {logic [4:0] addr; logic wr; logic [31:0] wd;} xfer_t;
   typedef struct {logic [15:0] c, r, g, b;} smp_t;
   xfer_t exp_q[$];
   smp_t  smp_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   // slave configuration (written by stimulus only)
   int          ws = 0;
   logic        stall = 1'b0;
   logic        err_en = 1'b0;
   logic [4:0]  err_addr = '0;
   int          stat_need = 0;
   int          stat_mark = 0;
   logic [31:0] d_c, d_r, d_g, d_b;

   // monitor state (written by monitor only)
   int          stat_cnt = 0;
   int          acc_n = 0, last_run = 0, idle_run = 0, hs_dist = 0;
   logic        after_hs = 0, hs_chk = 0, low_chk = 0, prev_status = 0;
   logic [4:0]  setup_addr = '0;

   always #5 clk = ~clk;

   senzor_poll_ctrl #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32), .POLL_GAP(POLL_GAP),
      .MAX_POLLS(MAX_POLLS), .PREADY_TO(PREADY_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_gain(cfg_gain), .cfg_itime(cfg_itime),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .smp_valid(smp_valid), .smp_ready(smp_ready),
      .smp_c(smp_c), .smp_r(smp_r), .smp_g(smp_g), .smp_b(smp_b),
      .busy(busy), .err(err), .err_code(err_code)
   );

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_word(input logic [1:0] gain, input logic [7:0] itime);
      return (32'(itime) << 8) | (32'(gain) << 1) | 32'd1;
   endfunction

   function automatic logic [31:0] rd_val(input logic [4:0] a);
      case (a)
         5'h04:   rd_val = ((stat_cnt - stat_mark) >= stat_need) ? 32'd1 : 32'd0;
         5'h08:   rd_val = d_c;
         5'h0C:   rd_val = d_r;
         5'h10:   rd_val = d_g;
         5'h14:   rd_val = d_b;
         default: rd_val = 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic cond(input int kind);
      case (kind)
         0:       cond = smp_valid;
         1:       cond = !busy;
         2:       cond = psel && (paddr == 5'h10);
         default: cond = penable;
      endcase
   endfunction

   task automatic wait_until(input int kind, input int budget, input string tag);
      int n = 0;
      while (!cond(kind) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(64'(cond(kind)), 64'd1, tag);
   endtask

   task automatic push_x(input logic [4:0] a, input logic w, input logic [31:0] d);
      xfer_t e;
      e.addr = a; e.wr = w; e.wd = d;
      exp_q.push_back(e);
   endtask

   task automatic push_s(input logic [15:0] c, r, g, b);
      smp_t s;
      s.c = c; s.r = r; s.g = g; s.b = b;
      smp_q.push_back(s);
   endtask

   task automatic pulse_start(input logic [1:0] g, input logic [7:0] it, input logic with_stop);
      cfg_gain = g; cfg_itime = it; start = 1'b1; stop = with_stop;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; cfg_gain = '0; cfg_itime = '0;
   endtask

   // APB slave model plus protocol/scoreboard monitor, all at negedge
   always @(negedge clk) begin
      if (!rst_n) begin
         pready = 1'b0; prdata = '0; pslverr = 1'b0;
         acc_n = 0; idle_run = 0; after_hs = 0; hs_chk = 0; low_chk = 0; prev_status = 0;
      end else begin
         if (after_hs) hs_dist++;
         if (hs_chk) begin chk(64'(smp_valid), 64'd0, "valid_drop_after_hs"); hs_chk = 0; end
         if (low_chk) begin chk(64'(psel), 64'd0, "psel_low_after_cfg"); low_chk = 0; end
         if (psel && !penable) begin
            setup_addr = paddr;
            if (paddr == 5'h04 && !pwrite) begin
               if (prev_status) chk(64'(idle_run), 64'(POLL_GAP), "poll_gap_idle");
               if (after_hs)    chk(64'(hs_dist), 64'(POLL_GAP + 1), "poll_after_sample");
            end
            after_hs = 0;
         end
         if (psel) idle_run = 0; else idle_run++;
         if (psel && penable) acc_n++;
         else begin
            if (acc_n != 0) last_run = acc_n;
            acc_n = 0;
         end
         pready = 1'b0; prdata = '0; pslverr = 1'b0;
         if (psel && penable && !stall && acc_n > ws) begin
            pready  = 1'b1;
            pslverr = err_en && (paddr == err_addr);
            prdata  = rd_val(paddr);
            if (paddr == 5'h04 && !pwrite) stat_cnt++;
            chk(64'(setup_addr), 64'(paddr), "setup_addr_stable");
            if (exp_q.size() != 0) begin
               xfer_t e;
               e = exp_q.pop_front();
               chk({paddr, pwrite, pwdata}, {e.addr, e.wr, e.wd}, "apb_xfer");
            end else begin
               chk(64'(exp_q.size()), 64'd1, "unexpected_xfer");
            end
            prev_status = (paddr == 5'h04) && !pwrite;
            if (pwrite && paddr == 5'h00 && pwdata[0]) low_chk = 1;
         end
         if (smp_valid) begin
            chk(64'(psel), 64'd0, "no_apb_while_valid");
            if (smp_q.size() != 0) begin
               chk({smp_c, smp_r, smp_g, smp_b},
                   {smp_q[0].c, smp_q[0].r, smp_q[0].g, smp_q[0].b}, "sample");
               if (smp_ready) begin
                  void'(smp_q.pop_front());
                  hs_chk = 1; after_hs = 1; hs_dist = 0;
               end
            end else begin
               chk(64'(smp_q.size()), 64'd1, "unexpected_sample");
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; smp_ready = 1'b0;
      cfg_gain = '0; cfg_itime = '0;
      d_c = '0; d_r = '0; d_g = '0; d_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk({psel, penable, pwrite, smp_valid, busy, err}, 0, "rst_ctrl");
      chk({paddr, pwdata}, 0, "rst_apb_bus");
      chk({smp_c, smp_r, smp_g, smp_b}, 0, "rst_channels");
      chk(err_code, 0, "rst_err_code");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // configure and first sample: two not-ready polls, then ready
      ws = 0; stat_need = 2; stat_mark = stat_cnt;
      d_c = 32'h0000_1234; d_r = 32'h0000_00AA; d_g = 32'h0000_00BB; d_b = 32'hABCD_00CC;
      push_x(5'h00, 1'b1, 32'h0000_4005);
      repeat (3) push_x(5'h04, 1'b0, 32'h0);
      push_x(5'h08, 1'b0, 32'h0); push_x(5'h0C, 1'b0, 32'h0);
      push_x(5'h10, 1'b0, 32'h0); push_x(5'h14, 1'b0, 32'h0);
      push_s(16'h1234, 16'h00AA, 16'h00BB, 16'h00CC);
      pulse_start(2'd2, 8'h40, 1'b0);
      chk(64'(busy), 64'd1, "busy_after_start");
      wait_until(0, 400, "wait_sample1");
      repeat (20) @(posedge clk);
      #1;
      chk(64'(exp_q.size()), 64'd0, "s1_xfers_done");

      // second sample with wait states; stop during RD_G
      ws = 3; stat_need = 0; stat_mark = stat_cnt;
      d_c = 32'hFFFF_1111; d_r = 32'h0000_2222; d_g = 32'h0000_3333; d_b = 32'h0000_4444;
      push_x(5'h04, 1'b0, 32'h0);
      push_x(5'h08, 1'b0, 32'h0); push_x(5'h0C, 1'b0, 32'h0);
      push_x(5'h10, 1'b0, 32'h0); push_x(5'h14, 1'b0, 32'h0);
      push_x(5'h00, 1'b1, 32'h0);
      push_s(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      smp_ready = 1'b1;
      @(posedge clk); #1;
      smp_ready = 1'b0;
      wait_until(2, 200, "wait_rd_g");
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_until(0, 200, "wait_sample2");
      repeat (3) @(posedge clk);
      #1;
      smp_ready = 1'b1;
      @(posedge clk); #1;
      smp_ready = 1'b0;
      wait_until(1, 200, "stop_to_idle");
      chk({err, err_code}, 0, "stop_no_err");
      chk(64'(exp_q.size()), 64'd0, "s2_xfers_done");

      // slave error on DATA_R
      ws = 0; stat_need = 0; stat_mark = stat_cnt; err_en = 1'b1; err_addr = 5'h0C;
      push_x(5'h00, 1'b1, ctrl_word(2'd1, 8'hFF));
      push_x(5'h04, 1'b0, 32'h0); push_x(5'h08, 1'b0, 32'h0); push_x(5'h0C, 1'b0, 32'h0);
      pulse_start(2'd1, 8'hFF, 1'b0);
      wait_until(1, 200, "slverr_to_idle");
      chk({err, err_code}, {1'b1, 2'd1}, "slverr_code");
      chk(64'(exp_q.size()), 64'd0, "s3_xfers_done");
      err_en = 1'b0;

      // start with stop in the same cycle: CFG write, then disable
      push_x(5'h00, 1'b1, ctrl_word(2'd3, 8'h05));
      push_x(5'h00, 1'b1, 32'h0);
      pulse_start(2'd3, 8'h05, 1'b1);
      chk(64'(err), 64'd0, "err_cleared_on_start");
      wait_until(1, 200, "start_stop_to_idle");
      chk({err, err_code}, 0, "start_stop_no_err");
      chk(64'(exp_q.size()), 64'd0, "s4_xfers_done");

      // STATUS never ready: poll timeout after MAX_POLLS reads
      stat_need = 1_000_000; stat_mark = stat_cnt;
      push_x(5'h00, 1'b1, ctrl_word(2'd0, 8'h10));
      for (int i = 0; i < MAX_POLLS; i++) push_x(5'h04, 1'b0, 32'h0);
      push_x(5'h00, 1'b1, 32'h0);
      pulse_start(2'd0, 8'h10, 1'b0);
      wait_until(1, 8000, "poll_to_idle");
      chk({err, err_code}, {1'b1, 2'd3}, "poll_timeout_code");
      chk(64'(exp_q.size()), 64'd0, "s5_xfers_done");

      // pready never returned: access timeout
      stall = 1'b1;
      push_x(5'h00, 1'b1, ctrl_word(2'd1, 8'h01));
      pulse_start(2'd1, 8'h01, 1'b0);
      wait_until(1, 300, "rdy_to_idle");
      @(negedge clk); #1;
      chk({err, err_code}, {1'b1, 2'd2}, "rdy_timeout_code");
      chk(64'(last_run), 64'(PREADY_TO), "rdy_timeout_len");
      chk({psel, penable}, 0, "rdy_timeout_bus_drop");
      chk(64'(exp_q.size()), 64'd1, "rdy_timeout_pending");
      exp_q.delete();
      @(posedge clk); #1;

      // reset in the middle of an ACCESS phase
      pulse_start(2'd2, 8'h22, 1'b0);
      wait_until(3, 20, "wait_access");
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk({psel, penable, busy}, 0, "async_rst_drop");
      @(posedge clk); #2;
      stall = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk({err, err_code, smp_valid}, 0, "post_rst_state");

      chk(64'(smp_q.size()), 64'd0, "samples_consumed");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
